// File: rtl/sti_dac_multi_if.sv
// Bus bundle for the serial transmitter / DAC-memory loader: parallel load side,
// serial output and bank-write port.
interface sti_dac_multi_if #(
    parameter int NBANK  = 4,
    parameter int ADDR_W = 5
);
    logic                 load;
    logic [15:0]          pi_data;
    logic [1:0]           pi_length;
    logic                 pi_fill;
    logic                 pi_msb;
    logic                 pi_low;
    logic                 pi_end;
    logic                 pi_ready;
    logic                 so_valid;
    logic                 so_data;
    logic [2*NBANK-1:0]   oem_wr;
    logic [ADDR_W-1:0]    oem_addr;
    logic [7:0]           oem_dataout;
    logic                 oem_finish;
    logic                 oem_ovf;

    modport master (
        output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
        input  pi_ready, so_valid, so_data, oem_wr, oem_addr, oem_dataout,
               oem_finish, oem_ovf
    );

    modport slave (
        input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
        output pi_ready, so_valid, so_data, oem_wr, oem_addr, oem_dataout,
               oem_finish, oem_ovf
    );
endinterface

// File: rtl/sti_dac_multi.sv
// Serial transmitter that also packs its bit stream into bytes and writes them
// interleaved across odd/even DAC bank pairs, zero-filling memory after the last word.
module sti_dac_multi #(
    parameter int NBANK   = 4,
    parameter int ADDR_W  = 5,
    parameter int CHECKER = 1
) (
    input  logic            clk,
    input  logic            reset,
    sti_dac_multi_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TOTAL = 2 * NBANK * DEPTH;
    localparam int NW    = $clog2(TOTAL + 1);
    localparam int GW    = NW - ADDR_W - 1;

    typedef enum logic [1:0] {IDLE, SHIFT, FILL, DONE} state_t;
    state_t state_reg, state_next;

    logic [31:0]        tx_reg, word, word_rev, tx_load;
    logic [4:0]         bit_cnt_reg, last_bit_reg, len_m1;
    logic               end_reg;
    logic [6:0]         byte_reg;
    logic [NW-1:0]      n_reg, n_next;
    logic [2*NBANK-1:0] wr_reg, wr_sel;
    logic [ADDR_W-1:0]  addr_reg;
    logic [7:0]         data_reg, wr_data;
    logic               finish_reg, ovf_reg;
    logic               byte_done, last_bit, n_full, do_write, sel;
    logic [GW-1:0]      grp;
    logic [ADDR_W:0]    k;

    // The word is left-aligned so the next bit to send is always tx_reg[31].
    always_comb begin
        word = '0;
        case (bus.pi_length)
            2'd0:    word = {24'h0, bus.pi_low ? bus.pi_data[15:8] : bus.pi_data[7:0]};
            2'd1:    word = {16'h0, bus.pi_data};
            2'd2:    word = bus.pi_fill ? {8'h0, bus.pi_data, 8'h0} : {16'h0, bus.pi_data};
            default: word = bus.pi_fill ? {bus.pi_data, 16'h0} : {16'h0, bus.pi_data};
        endcase
        for (int i = 0; i < 32; i++) begin
            word_rev[i] = word[31-i];
        end
        len_m1  = {bus.pi_length, 3'b111};
        tx_load = bus.pi_msb ? (word << (5'd31 - len_m1)) : word_rev;
    end

    assign n_full    = (n_reg == NW'(TOTAL));
    assign byte_done = (state_reg == SHIFT) && (bit_cnt_reg[2:0] == 3'b111);
    assign last_bit  = (state_reg == SHIFT) && (bit_cnt_reg == last_bit_reg);
    assign do_write  = !n_full && (byte_done || (state_reg == FILL));
    assign wr_data   = (state_reg == FILL) ? 8'h00 : {byte_reg, tx_reg[31]};
    assign n_next    = do_write ? n_reg + 1'b1 : n_reg;

    assign grp = n_reg[NW-1:ADDR_W+1];
    assign k   = n_reg[ADDR_W:0];

    generate
        if (CHECKER != 0) begin : g_checker
            assign sel = k[0] ^ k[3];
        end else begin : g_plain
            assign sel = k[0];
        end
        for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
            assign wr_sel[gi]       = (grp == GW'(gi)) && !sel;
            assign wr_sel[NBANK+gi] = (grp == GW'(gi)) && sel;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (bus.load) state_next = SHIFT;
            SHIFT: begin
                if (last_bit) begin
                    if (!end_reg)                   state_next = IDLE;
                    else if (n_next < NW'(TOTAL))   state_next = FILL;
                    else                            state_next = DONE;
                end
            end
            FILL:  if (n_next == NW'(TOTAL)) state_next = DONE;
            default: state_next = DONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            tx_reg       <= '0;
            bit_cnt_reg  <= '0;
            last_bit_reg <= '0;
            end_reg      <= 1'b0;
            byte_reg     <= '0;
            n_reg        <= '0;
            wr_reg       <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            finish_reg   <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            n_reg      <= n_next;
            wr_reg     <= '0;
            finish_reg <= (state_reg == DONE);
            if (state_reg == IDLE && bus.load) begin
                tx_reg       <= tx_load;
                bit_cnt_reg  <= '0;
                last_bit_reg <= len_m1;
                end_reg      <= bus.pi_end;
            end else if (state_reg == SHIFT) begin
                tx_reg      <= {tx_reg[30:0], 1'b0};
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                byte_reg    <= {byte_reg[5:0], tx_reg[31]};
            end
            if (do_write) begin
                wr_reg   <= wr_sel;
                addr_reg <= k[ADDR_W:1];
                data_reg <= wr_data;
            end
            if (byte_done && n_full) ovf_reg <= 1'b1;
        end
    end

    assign bus.pi_ready    = (state_reg == IDLE);
    assign bus.so_valid    = (state_reg == SHIFT);
    assign bus.so_data     = (state_reg == SHIFT) & tx_reg[31];
    assign bus.oem_wr      = wr_reg;
    assign bus.oem_addr    = addr_reg;
    assign bus.oem_dataout = data_reg;
    assign bus.oem_finish  = finish_reg;
    assign bus.oem_ovf     = ovf_reg;
endmodule
